alu_share_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 32-bit ALU in the CPU datapath. Accepts operations from two independent requesters over valid/ready handshakes, grants one at a time, drives the ALU operand/command lines stably for a fixed settle window, then captures and returns the registered flags and result on a single tagged response channel. Sits between the execute stage and the auxiliary address-compute path and the one structural ALU instance.

---
 rtl/alu_defs_pkg.sv | 24 ++
 rtl/alu_share_arbiter_if.sv | 49 ++++
 rtl/alu_rr_grant.sv | 23 ++
 rtl/alu_share_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU share arbiter: command codes, sequencer states, requester id type.
package alu_defs_pkg;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ID_W = 1;
    typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester, ALU and response signal bundle for alu_share_arbiter.
interface alu_share_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_cmd;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_cmd;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_command;
    logic [31:0] alu_result;
    logic        alu_carryout;
    logic        alu_overflow;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_carryout;
    logic        rsp_overflow;
    logic        rsp_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cmd,
        input  req1_valid, req1_a, req1_b, req1_cmd,
        input  alu_result, alu_carryout, alu_overflow,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_command,
        output rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cmd,
        output req1_valid, req1_a, req1_b, req1_cmd,
        output alu_result, alu_carryout, alu_overflow,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_command,
        input  rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero
    );
endinterface

// File: rtl/alu_rr_grant.sv
// Two-way grant selection. ALU_ARB_FIXED_PRIORITY_EN makes req0 win every tie;
// otherwise ties go to the requester that was not served last.
module alu_rr_grant
    import alu_defs_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_t last,
    output logic    gnt,
    output req_id_t gnt_id
);

    assign gnt = valid0 | valid1;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
    logic unused_last;
    assign unused_last = |last;
    assign gnt_id      = req_id_t'(!valid0);
`else
    assign gnt_id = (valid0 && valid1) ? ~last : req_id_t'(!valid0);
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbiter/sequencer for the shared ALU: grant, hold operands for a settle window, return tagged result.
// Build option: ALU_ARB_FIXED_PRIORITY_EN selects fixed req0 priority instead of round-robin.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch operands in the same cycle
// EXEC  | operands held on the ALU while the settle counter runs down
// RESP  | captured result presented until the consumer takes it
module alu_share_arbiter
    import alu_defs_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input logic                clk,
    input logic                reset,
    alu_share_arbiter_if.slave bus
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [3:0]  settle_cnt;
    req_id_t     last_id;
    req_id_t     owner_id;
    req_id_t     gnt_id;
    logic        gnt_any;
    logic        accept;
    logic        capture;
    logic        rsp_valid;

    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    alu_cmd_t    alu_cmd_q;
    req_id_t     rsp_id_q;
    logic [31:0] rsp_result_q;
    logic        rsp_carry_q;
    logic        rsp_ovf_q;
    logic        rsp_zero_q;

    alu_rr_grant u_grant (
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .last   (last_id),
        .gnt    (gnt_any),
        .gnt_id (gnt_id)
    );

    // Readies are suppressed during reset so nothing is acknowledged that will be dropped.
    assign accept         = (state == IDLE) && gnt_any && !reset;
    assign bus.req0_ready = accept && (gnt_id == req_id_t'(0));
    assign bus.req1_ready = accept && (gnt_id == req_id_t'(1));
    assign capture        = (state == EXEC) && (settle_cnt == 4'd1);
    assign rsp_valid      = (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_any) state_next = EXEC;
            EXEC:    if (settle_cnt == 4'd1) state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_cmd_q    <= CMD_ADD;
            owner_id     <= req_id_t'(0);
            settle_cnt   <= 4'd0;
            rsp_id_q     <= req_id_t'(0);
            rsp_result_q <= 32'd0;
            rsp_carry_q  <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
            last_id      <= req_id_t'(1);
        end else begin
            if (accept) begin
                if (gnt_id == req_id_t'(1)) begin
                    alu_a_q   <= bus.req1_a;
                    alu_b_q   <= bus.req1_b;
                    alu_cmd_q <= alu_cmd_t'(bus.req1_cmd);
                end else begin
                    alu_a_q   <= bus.req0_a;
                    alu_b_q   <= bus.req0_b;
                    alu_cmd_q <= alu_cmd_t'(bus.req0_cmd);
                end
                owner_id   <= gnt_id;
                settle_cnt <= SETTLE_LOAD;
            end else if (state == EXEC) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (capture) begin
                rsp_id_q     <= owner_id;
                rsp_result_q <= bus.alu_result;
                rsp_carry_q  <= bus.alu_carryout;
                rsp_ovf_q    <= bus.alu_overflow;
                rsp_zero_q   <= (bus.alu_result == 32'd0);
            end

            if (rsp_valid && bus.rsp_ready) begin
                last_id <= owner_id;
            end
        end
    end

    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.alu_command  = alu_cmd_q;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_carryout = rsp_carry_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign bus.rsp_zero     = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU and arbitration model.
module tb_alu_share_arbiter;

    localparam int SETTLE = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    alu_share_arbiter_if bus ();

    alu_share_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int last_served = 1;
    logic [31:0] op_a [2];
    logic [31:0] op_b [2];
    logic [2:0]  op_c [2];

    // Returns {carry, overflow, result}
    function automatic logic [33:0] alu_ref(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic c;
        logic o;
        s = 33'd0;
        r = 32'd0;
        c = 1'b0;
        o = 1'b0;
        case (cmd)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0];
                c = s[32];
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a ^ b;
            3'd3: r = {31'd0, ($signed(a) < $signed(b))};
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {c, o, r};
    endfunction

    always_comb begin
        {bus.alu_carryout, bus.alu_overflow, bus.alu_result} = alu_ref(bus.alu_command, bus.alu_a, bus.alu_b);
    end

    // Returns {id, carry, overflow, zero, result}
    function automatic logic [35:0] exp_rsp(input int id);
        logic [33:0] v;
        logic        idb;
        v   = alu_ref(op_c[id], op_a[id], op_b[id]);
        idb = (id == 1);
        return {idb, v[33], v[32], (v[31:0] == 32'd0), v[31:0]};
    endfunction

    function automatic logic [35:0] obs_rsp();
        return {bus.rsp_id, bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero, bus.rsp_result};
    endfunction

    function automatic int exp_winner(input logic v0, input logic v1);
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        return v0 ? 0 : 1;
`else
        if (v0 && v1) return (last_served == 0) ? 1 : 0;
        return v0 ? 0 : 1;
`endif
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        op_a[id] = a;
        op_b[id] = b;
        op_c[id] = c;
        if (id == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_cmd = c;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_cmd = c;
        end
    endtask

    task automatic rand_req(input int id);
        logic [2:0] c;
        c = 3'($urandom_range(0, 7));
        set_req(id, rnd_word(), rnd_word(), c);
    endtask

    task automatic drive_valid(input logic v0, input logic v1);
        bus.req0_valid = v0;
        bus.req1_valid = v1;
    endtask

    // Returns at the negedge after the accepting edge; id = -1 on timeout.
    task automatic wait_grant(output int id, output logic both);
        id = -1;
        both = 1'b0;
        for (int i = 0; i < 50 && id < 0; i++) begin
            #1;
            both = bus.req0_ready && bus.req1_ready;
            if (bus.req0_ready) id = 0;
            else if (bus.req1_ready) id = 1;
            else @(negedge clk);
        end
        if (id >= 0) @(negedge clk);
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!bus.rsp_valid && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_valid(1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        last_served = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rand_req(0);
        rand_req(1);
        drive_valid(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_readies: got %b expected 00", {bus.req0_ready, bus.req1_ready});
            end
        end
        n_checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_command} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_alu: got a=%h b=%h cmd=%0d expected all 0", bus.alu_a, bus.alu_b, bus.alu_command);
        end
        n_checks++;
        if ({bus.rsp_valid, obs_rsp()} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: got valid=%b rsp=%h expected all 0", bus.rsp_valid, obs_rsp());
        end
        @(negedge clk);
        reset = 1'b0;
        drive_valid(1'b0, 1'b0);
        last_served = 1;
    endtask

    task automatic test_single();
        int id;
        int cyc;
        logic both;
        set_req(0, 32'd2, 32'd1, 3'd0);
        drive_valid(1'b1, 1'b0);
        wait_grant(id, both);
        n_checks++;
        if (id !== exp_winner(1'b1, 1'b0) || both) begin
            n_fail++;
            $display("FAIL single_grant: got id=%0d both=%b expected id=0 both=0", id, both);
        end
        drive_valid(1'b0, 1'b0);
        wait_rsp(cyc);
        n_checks++;
        if (cyc != SETTLE) begin
            n_fail++;
            $display("FAIL single_latency: got %0d expected %0d", cyc, SETTLE);
        end
        n_checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_command} !== {32'd2, 32'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL single_alu: got a=%h b=%h cmd=%0d expected 2 1 0", bus.alu_a, bus.alu_b, bus.alu_command);
        end
        n_checks++;
        if (obs_rsp() !== {1'b0, 3'b000, 32'd3}) begin
            n_fail++;
            $display("FAIL single_rsp: got %h expected %h", obs_rsp(), {1'b0, 3'b000, 32'd3});
        end
        last_served = 0;
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp_drop: got %b expected 0", bus.rsp_valid);
        end
    endtask

    task automatic test_tie();
        int id;
        int cyc;
        logic both;
        logic [35:0] exp;
        do_reset();
        set_req(0, 32'h8000_0000, 32'h8000_0000, 3'd0);
        set_req(1, 32'd5, 32'd5, 3'd1);
        drive_valid(1'b1, 1'b1);
        wait_grant(id, both);
        n_checks++;
        if (id !== exp_winner(1'b1, 1'b1) || both) begin
            n_fail++;
            $display("FAIL tie_first_grant: got id=%0d both=%b expected id=%0d", id, both, exp_winner(1'b1, 1'b1));
        end
        drive_valid(1'b0, 1'b1);
        wait_rsp(cyc);
        exp = exp_rsp(0);
        n_checks++;
        if (obs_rsp() !== exp) begin
            n_fail++;
            $display("FAIL tie_first_rsp: got %h expected %h", obs_rsp(), exp);
        end
        last_served = 0;
        @(negedge clk);
        wait_grant(id, both);
        n_checks++;
        if (id !== 1) begin
            n_fail++;
            $display("FAIL tie_second_grant: got id=%0d expected 1", id);
        end
        drive_valid(1'b0, 1'b0);
        wait_rsp(cyc);
        exp = exp_rsp(1);
        n_checks++;
        if (obs_rsp() !== exp) begin
            n_fail++;
            $display("FAIL tie_second_rsp: got %h expected %h", obs_rsp(), exp);
        end
        last_served = 1;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int id;
        int cyc;
        logic both;
        logic [35:0] exp;
        logic bad;
        bus.rsp_ready = 1'b0;
        rand_req(0);
        rand_req(1);
        drive_valid(1'b1, 1'b1);
        wait_grant(id, both);
        n_checks++;
        if (id !== exp_winner(1'b1, 1'b1) || both) begin
            n_fail++;
            $display("FAIL bp_grant: got id=%0d both=%b expected id=%0d", id, both, exp_winner(1'b1, 1'b1));
        end
        if (id < 0) id = 0;
        wait_rsp(cyc);
        exp = exp_rsp(id);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.rsp_valid !== 1'b1 || obs_rsp() !== exp || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
                {bus.alu_a, bus.alu_b, bus.alu_command} !== {op_a[id], op_b[id], op_c[id]}) bad = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_hold: got valid=%b rsp=%h rdy=%b%b expected valid=1 rsp=%h rdy=00 stable",
                     bus.rsp_valid, obs_rsp(), bus.req0_ready, bus.req1_ready, exp);
        end
        bus.rsp_ready = 1'b1;
        drive_valid(1'b0, 1'b0);
        @(negedge clk);
        last_served = id;
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got rsp_valid=%b expected 0", bus.rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int id;
        int cyc;
        logic both;
        logic [35:0] exp;
        int seq_exp;
        do_reset();
        rand_req(0);
        rand_req(1);
        drive_valid(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_grant(id, both);
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            seq_exp = 0;
`else
            seq_exp = k % 2;
`endif
            n_checks++;
            if (id !== seq_exp || id !== exp_winner(1'b1, 1'b1) || both) begin
                n_fail++;
                $display("FAIL stream_id[%0d]: got id=%0d both=%b expected %0d", k, id, both, seq_exp);
            end
            if (id < 0) id = 0;
            exp = exp_rsp(id);
            rand_req(id);
            wait_rsp(cyc);
            n_checks++;
            if (obs_rsp() !== exp) begin
                n_fail++;
                $display("FAIL stream_rsp[%0d]: got %h expected %h", k, obs_rsp(), exp);
            end
            last_served = id;
            @(negedge clk);
        end
        drive_valid(1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int id;
        int cyc;
        logic both;
        logic [35:0] exp;
        logic seen;
        rand_req(0);
        drive_valid(1'b1, 1'b0);
        wait_grant(id, both);
        drive_valid(1'b0, 1'b0);
        wait_rsp(cyc);
        last_served = 0;
        @(negedge clk);
        rand_req(1);
        drive_valid(1'b0, 1'b1);
        wait_grant(id, both);
        drive_valid(1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_served = 1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.alu_a !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_idle: got rsp_valid=%b alu_a=%h expected 0 0", bus.rsp_valid, bus.alu_a);
        end
        seen = 1'b0;
        for (int i = 0; i < SETTLE + 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL midreset_discard: got rsp_valid=1 expected 0 throughout");
        end
        rand_req(0);
        rand_req(1);
        drive_valid(1'b1, 1'b1);
        wait_grant(id, both);
        n_checks++;
        if (id !== 0) begin
            n_fail++;
            $display("FAIL midreset_tie: got id=%0d expected 0", id);
        end
        if (id < 0) id = 0;
        drive_valid(1'b0, 1'b0);
        wait_rsp(cyc);
        exp = exp_rsp(id);
        n_checks++;
        if (obs_rsp() !== exp) begin
            n_fail++;
            $display("FAIL midreset_rsp: got %h expected %h", obs_rsp(), exp);
        end
        last_served = id;
        @(negedge clk);
    endtask

    task automatic test_random();
        int id;
        int cyc;
        int pat;
        int hold;
        int want;
        logic both;
        logic [35:0] exp;
        for (int n = 0; n < 24; n++) begin
            pat = $urandom_range(1, 3);
            rand_req(0);
            rand_req(1);
            drive_valid(pat[0], pat[1]);
            want = exp_winner(pat[0], pat[1]);
            wait_grant(id, both);
            n_checks++;
            if (id !== want || both) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: got id=%0d both=%b expected %0d", n, id, both, want);
            end
            if (id < 0) id = 0;
            exp = exp_rsp(id);
            drive_valid(1'b0, 1'b0);
            hold = $urandom_range(0, 3);
            bus.rsp_ready = (hold == 0);
            wait_rsp(cyc);
            n_checks++;
            if (cyc != SETTLE) begin
                n_fail++;
                $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, cyc, SETTLE);
            end
            for (int h = 0; h < hold; h++) @(negedge clk);
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || obs_rsp() !== exp) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: got valid=%b rsp=%h expected valid=1 rsp=%h", n, bus.rsp_valid, obs_rsp(), exp);
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            last_served = id;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        set_req(0, 32'd0, 32'd0, 3'd0);
        set_req(1, 32'd0, 32'd0, 3'd0);
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
